// File: rtl/lsu_mem_req.sv
// rtl/lsu_mem_req.sv - load/store request stage with byte lanes and outstanding-load tracker (option: LSU_MISALIGN_TRAP_EN)
module lsu_mem_req #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              dmem_en,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_din,
    input  logic [XLEN-1:0]   dmem_dout,
    input  logic              dmem_rvalid,
    output logic              ld_valid,
    output logic [XLEN-1:0]   ld_data,
    output logic [1:0]        ld_sft,
    output logic [2:0]        ld_funct3,
    output logic              misalign,
    output logic              busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] FNC_B  = 3'b000;
    localparam logic [2:0] FNC_H  = 3'b001;
    localparam logic [2:0] FNC_W  = 3'b010;
    localparam logic [2:0] FNC_HU = 3'b101;

    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    fifo [DEPTH];

    logic [1:0]    off;
    logic          fire;
    logic          mis_op;
    logic          push;
    logic          pop;
    logic [3:0]    size_mask;
    logic [3:0]    lane_mask;
    logic [XLEN-1:0] lane_data;

    // Address bits above the word index never reach the memory port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[XLEN-1:ADDR_W+2];

    assign off       = req_addr[1:0];
    assign req_ready = (count < CW'(DEPTH));
    assign busy      = (count != '0);
    assign fire      = req_valid & req_ready;
    assign dmem_addr = req_addr[ADDR_W+1:2];

    // Misalignment is only detected when the trap option is built in.
`ifdef LSU_MISALIGN_TRAP_EN
    logic is_half;
    logic is_word;
    logic mis_q;
    assign is_half = (req_funct3 == FNC_H) | (~req_we & (req_funct3 == FNC_HU));
    assign is_word = (req_funct3 == FNC_W);
    assign mis_op  = (is_half & off[0]) | (is_word & (off != 2'b00));
    assign misalign = mis_q;

    // Registered one-cycle misalign pulse after the offending handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= fire & mis_op;
        end
    end
`else
    assign mis_op   = 1'b0;
    assign misalign = 1'b0;
`endif

    // Store byte-lane mask and lane-shifted data; shifts truncate past lane 3.
    always_comb begin
        size_mask = 4'b0000;
        case (req_funct3)
            FNC_B:   size_mask = 4'b0001;
            FNC_H:   size_mask = 4'b0011;
            FNC_W:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
        lane_mask = size_mask << off;
        lane_data = req_wdata << {off, 3'b000};
    end

    // Memory port strobes; load data bus is kept at zero.
    always_comb begin
        dmem_en  = fire & ~mis_op;
        dmem_we  = (fire & req_we & ~mis_op) ? lane_mask : 4'b0000;
        dmem_din = (fire & req_we) ? lane_data : '0;
    end

    assign push = fire & ~req_we & ~mis_op;
    assign pop  = dmem_rvalid & (count != '0);

    // Tracker occupancy and ring pointers; wrap is natural since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Tracker storage holds {offset, funct3} for each outstanding load.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= {off, req_funct3};
        end
    end

    // Registered load result; data and tags hold until the next response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            ld_sft    <= 2'b00;
            ld_funct3 <= 3'b000;
        end else begin
            ld_valid <= pop;
            if (pop) begin
                ld_data   <= dmem_dout;
                ld_sft    <= fifo[rd_ptr][4:3];
                ld_funct3 <= fifo[rd_ptr][2:0];
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_req.sv
// tb/tb_lsu_mem_req.sv - self-checking bench for lsu_mem_req
module tb_lsu_mem_req;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [2:0]        req_funct3;
    logic              dmem_en;
    logic [3:0]        dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_din;
    logic [XLEN-1:0]   dmem_dout;
    logic              dmem_rvalid;
    logic              ld_valid;
    logic [XLEN-1:0]   ld_data;
    logic [1:0]        ld_sft;
    logic [2:0]        ld_funct3;
    logic              misalign;
    logic              busy;

    lsu_mem_req #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_din(dmem_din), .dmem_dout(dmem_dout), .dmem_rvalid(dmem_rvalid),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_sft(ld_sft),
        .ld_funct3(ld_funct3), .misalign(misalign), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Number of bytes a funct3 accesses; 0 for encodings with no store meaning.
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] f3, input int o);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= o && i < o + nbytes(f3)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] placed(input logic [31:0] w, input int o);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i >= o) r[8*i +: 8] = w[8*(i-o) +: 8];
        return r;
    endfunction

    function automatic logic is_mis(input logic we, input logic [2:0] f3, input int o);
`ifdef LSU_MISALIGN_TRAP_EN
        logic half;
        half = we ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
        return (half && (o % 2 == 1)) || (f3 == 3'b010 && o != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference state: queue of outstanding {offset, funct3} and expected registered outputs.
    logic [4:0]  mq [$];
    logic        m_ldv;
    logic [31:0] m_ldd;
    logic [1:0]  m_sft;
    logic [2:0]  m_f3;
    logic        m_mis;
    logic        m_ready;
    logic        m_fire;
    logic        m_bad;
    logic [4:0]  m_head;
    int          m_off;

    initial begin
        m_ldv = 0; m_ldd = 0; m_sft = 0; m_f3 = 0; m_mis = 0;
    end

    // Compare every cycle, then advance the reference across the coming edge.
    always @(negedge clk) begin
        m_off   = int'(req_addr[1:0]);
        m_ready = (mq.size() < DEPTH);
        m_fire  = req_valid && m_ready;
        m_bad   = m_fire && is_mis(req_we, req_funct3, m_off);
        chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
        chk("busy", {31'b0, busy}, {31'b0, mq.size() != 0});
        chk("dmem_en", {31'b0, dmem_en}, {31'b0, m_fire && !m_bad});
        chk("dmem_we", {28'b0, dmem_we},
            (m_fire && req_we && !m_bad) ? {28'b0, lanes(req_funct3, m_off)} : 32'h0);
        chk("dmem_addr", {18'b0, dmem_addr}, {18'b0, req_addr[15:2]});
        if (!m_fire)
            chk("dmem_din_idle", dmem_din, 32'h0);
        else if (req_we)
            chk("dmem_din", dmem_din, placed(req_wdata, m_off));
        chk("ld_valid", {31'b0, ld_valid}, {31'b0, m_ldv});
        chk("ld_data", ld_data, m_ldd);
        chk("ld_sft", {30'b0, ld_sft}, {30'b0, m_sft});
        chk("ld_funct3", {29'b0, ld_funct3}, {29'b0, m_f3});
        chk("misalign", {31'b0, misalign}, {31'b0, m_mis});

        if (!rst_n) begin
            mq.delete();
            m_ldv = 0; m_ldd = 0; m_sft = 0; m_f3 = 0; m_mis = 0;
        end else begin
            m_ldv = 0;
            if (dmem_rvalid && mq.size() != 0) begin
                m_head = mq.pop_front();
                m_ldv = 1;
                m_ldd = dmem_dout;
                m_sft = m_head[4:3];
                m_f3  = m_head[2:0];
            end
            if (m_fire && !req_we && !m_bad)
                mq.push_back({req_addr[1:0], req_funct3});
            m_mis = m_bad;
        end
    end

    task automatic drive(input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic rv, input logic [31:0] dout);
        @(posedge clk);
        #1;
        req_valid = v; req_we = we; req_addr = addr; req_wdata = wdata;
        req_funct3 = f3; dmem_rvalid = rv; dmem_dout = dout;
    endtask

    task automatic idle(input logic rv, input logic [31:0] dout);
        drive(0, 0, 32'h0, 32'h0, 3'b000, rv, dout);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        req_funct3 = 0; dmem_rvalid = 0; dmem_dout = 0;
        idle(0, 0);
        idle(0, 0);
        settle();
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_ldv", {31'b0, ld_valid}, 32'h0);
        chk("rst_ldd", ld_data, 32'h0);
        @(posedge clk); #1; rst_n = 1;

        // SB to lane 3
        drive(1, 1, 32'h1003, 32'h000000A5, 3'b000, 0, 0);
        settle();
        chk("sb_we", {28'b0, dmem_we}, 32'h8);
        chk("sb_din", dmem_din, 32'hA5000000);
        chk("sb_addr", {18'b0, dmem_addr}, 32'h400);
        chk("sb_en", {31'b0, dmem_en}, 32'h1);

        // SH at offset 1
        drive(1, 1, 32'h2001, 32'h0000BEEF, 3'b001, 0, 0);
        settle();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("sh1_en", {31'b0, dmem_en}, 32'h0);
        chk("sh1_we", {28'b0, dmem_we}, 32'h0);
`else
        chk("sh1_we", {28'b0, dmem_we}, 32'h6);
        chk("sh1_din", dmem_din, 32'h00BEEF00);
`endif

        drive(1, 1, 32'h0100, 32'h12345678, 3'b010, 0, 0);
        settle();
        chk("sw_we", {28'b0, dmem_we}, 32'hF);
        chk("sw_din", dmem_din, 32'h12345678);

`ifndef LSU_MISALIGN_TRAP_EN
        drive(1, 1, 32'h3003, 32'h0000BEEF, 3'b001, 0, 0);
        settle();
        chk("sh3_we", {28'b0, dmem_we}, 32'h8);
        chk("sh3_din", dmem_din, 32'hEF000000);
`endif

        // Unknown store encoding strobes with no lanes
        drive(1, 1, 32'h0000, 32'hFFFFFFFF, 3'b011, 0, 0);
        settle();
        chk("unk_st_en", {31'b0, dmem_en}, 32'h1);
        chk("unk_st_we", {28'b0, dmem_we}, 32'h0);

        // LBU at offset 2 with response one cycle later
        drive(1, 0, 32'h0002, 32'h0, 3'b100, 0, 0);
        settle();
        chk("lbu_en", {31'b0, dmem_en}, 32'h1);
        idle(1, 32'h11223344);
        settle();
        chk("lbu_busy", {31'b0, busy}, 32'h1);
        idle(0, 0);
        settle();
        chk("lbu_ldv", {31'b0, ld_valid}, 32'h1);
        chk("lbu_ldd", ld_data, 32'h11223344);
        chk("lbu_sft", {30'b0, ld_sft}, 32'h2);
        chk("lbu_f3", {29'b0, ld_funct3}, 32'h4);
        idle(0, 0);
        settle();
        chk("hold_ldv", {31'b0, ld_valid}, 32'h0);
        chk("hold_ldd", ld_data, 32'h11223344);

        // Three back-to-back loads against a two-entry tracker
        drive(1, 0, 32'h0001, 32'h0, 3'b000, 0, 0);
        drive(1, 0, 32'h0003, 32'h0, 3'b000, 0, 0);
        drive(1, 0, 32'h0004, 32'h0, 3'b000, 0, 0);
        settle();
        chk("full_ready", {31'b0, req_ready}, 32'h0);
        chk("full_en", {31'b0, dmem_en}, 32'h0);
        drive(1, 0, 32'h0004, 32'h0, 3'b000, 1, 32'hAAAA0001);
        drive(1, 0, 32'h0004, 32'h0, 3'b000, 0, 0);
        settle();
        chk("drain_ready", {31'b0, req_ready}, 32'h1);
        chk("r1_ldd", ld_data, 32'hAAAA0001);
        chk("r1_sft", {30'b0, ld_sft}, 32'h1);
        idle(1, 32'hBBBB0002);
        idle(1, 32'hCCCC0003);
        settle();
        chk("r2_sft", {30'b0, ld_sft}, 32'h3);
        chk("r2_ldd", ld_data, 32'hBBBB0002);
        idle(0, 0);
        settle();
        chk("r3_sft", {30'b0, ld_sft}, 32'h0);
        chk("r3_ldd", ld_data, 32'hCCCC0003);

        // Spurious response is ignored
        idle(1, 32'hDEADBEEF);
        idle(0, 0);
        settle();
        chk("spur_ldv", {31'b0, ld_valid}, 32'h0);
        chk("spur_ldd", ld_data, 32'hCCCC0003);

        // Push and pop in the same cycle
        drive(1, 0, 32'h0010, 32'h0, 3'b010, 0, 0);
        drive(1, 0, 32'h0012, 32'h0, 3'b001, 1, 32'h00000055);
        idle(1, 32'h00000066);
        settle();
        chk("pp_busy", {31'b0, busy}, 32'h1);
        chk("pp_f3a", {29'b0, ld_funct3}, 32'h2);
        idle(0, 0);
        settle();
        chk("pp_sft", {30'b0, ld_sft}, 32'h2);
        chk("pp_f3b", {29'b0, ld_funct3}, 32'h1);
        chk("pp_ldd", ld_data, 32'h00000066);
        chk("pp_idle", {31'b0, busy}, 32'h0);

        // Unknown load encoding passes through
        drive(1, 0, 32'h0001, 32'h0, 3'b011, 0, 0);
        idle(1, 32'h00000077);
        idle(0, 0);
        settle();
        chk("unk_ld_f3", {29'b0, ld_funct3}, 32'h3);

`ifdef LSU_MISALIGN_TRAP_EN
        drive(1, 0, 32'h0006, 32'h0, 3'b010, 0, 0);
        settle();
        chk("mis_en", {31'b0, dmem_en}, 32'h0);
        idle(0, 0);
        settle();
        chk("mis_pulse", {31'b0, misalign}, 32'h1);
        chk("mis_busy", {31'b0, busy}, 32'h0);
`endif

        // Reset discards outstanding loads; later responses are spurious
        drive(1, 0, 32'h0000, 32'h0, 3'b000, 0, 0);
        drive(1, 0, 32'h0001, 32'h0, 3'b000, 0, 0);
        idle(0, 0);
        rst_n = 0;
        idle(0, 0);
        rst_n = 1;
        idle(1, 32'h99999999);
        idle(1, 32'h88888888);
        idle(0, 0);
        settle();
        chk("rr_busy", {31'b0, busy}, 32'h0);
        chk("rr_ldv", {31'b0, ld_valid}, 32'h0);
        chk("rr_ldd", ld_data, 32'h0);
        chk("rr_sft", {30'b0, ld_sft}, 32'h0);
        chk("rr_f3", {29'b0, ld_funct3}, 32'h0);

        idle(0, 0);
        idle(0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_req.md
# lsu_mem_req

Load/store request stage between execute and the data memory/MMIO port. Accepts one memory op per cycle from execute, drives byte-lane write enables and lane-shifted store data, and tracks up to two outstanding loads. On each memory response it registers the raw word together with the byte offset and funct3 captured at issue. The load data alignment stage downstream consumes `ld_data`/`ld_sft`/`ld_funct3` directly.

## Interface
- `ADDR_W`, 14: word-address width of `dmem_addr`.
- `DEPTH`, 2: outstanding-load tracker entries; power of two, 2..4.

- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: execute presents a memory op.
- `req_ready`  out  1: `(count < DEPTH)`; does not depend on `req_valid` or `req_we`.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_addr`  in  `XLEN`: byte address.
- `req_wdata`  in  `XLEN`: store data, unshifted.
- `req_funct3`  in  3: `FNC_*` encoding (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `dmem_en`  out  1: memory access strobe.
- `dmem_we`  out  4: byte write enables.
- `dmem_addr`  out  `ADDR_W`: equals `req_addr[ADDR_W+1:2]`.
- `dmem_din`  out  `XLEN`: lane-shifted store data.
- `dmem_dout`  in  `XLEN`: read data, valid with `dmem_rvalid`.
- `dmem_rvalid`  in  1: one in-order load response per pulse.
- `ld_valid`  out  1: registered load result valid, one-cycle pulse.
- `ld_data`  out  `XLEN`: raw memory word.
- `ld_sft`  out  2: byte offset captured at issue.
- `ld_funct3`  out  3: funct3 captured at issue.
- `misalign`  out  1: one-cycle pulse, misaligned op rejected (see Configuration).
- `busy`  out  1: `count != 0`.

## Operation
- Handshake: `fire = req_valid & req_ready`. `off = req_addr[1:0]`.
- Store on `fire`:
  - `dmem_en = 1`.
  - `dmem_din = req_wdata << (8*off)`.
  - `dmem_we = (mask << off) & 4'hF`, where mask is SB `0001`, SH `0011`, SW `1111`.
  - The tracker is unchanged.
- Load on `fire`:
  - `dmem_en = 1`, `dmem_we = 0`.
  - `{off, funct3}` is pushed into the tracker FIFO.
- Without `fire`: `dmem_en = 0`, `dmem_we = 0`, `dmem_din = 0`.
- Response, when `dmem_rvalid` is high and `count != 0`:
  - Pop the FIFO head.
  - Next cycle, drive `ld_valid = 1` with `ld_data = dmem_dout` and `ld_sft`/`ld_funct3` from the popped entry.
  - `ld_data`, `ld_sft` and `ld_funct3` hold their values until the next response.
- Spurious response (`dmem_rvalid` with `count == 0`): ignored; no pop, no `ld_valid`.
- Push and pop in the same cycle: `count` is unchanged; rd/wr pointers both advance, modulo `DEPTH`.
- Unknown funct3 on a store: `dmem_we = 0`; the access still strobes `dmem_en`.
- Unknown funct3 on a load: passed through; the downstream stage outputs 0.

## Timing
- `dmem_en`/`dmem_we`/`dmem_addr`/`dmem_din` are combinational from the request in the `fire` cycle. Memory samples them at the same edge.
- Load latency: memory asserts `dmem_rvalid` at cycle N, `ld_valid` follows at N+1. Issue to result is at least 2 cycles with single-cycle BRAM.
- Throughput: one op per cycle. Back-to-back loads sustain one per cycle when `DEPTH >= 2`.
- `misalign` is registered, asserted the cycle after the offending `fire`.
- Reset, while `rst_n == 0` at a rising edge:
  - `count = 0`, pointers 0.
  - `ld_valid = 0`, `ld_data = 0`, `ld_sft = 0`, `ld_funct3 = 0`, `misalign = 0`.
  - Combinational outputs follow (`busy = 0`, `req_ready = 1`).
- Reset mid-operation discards outstanding entries. Responses arriving after reset are treated as spurious.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned ops are any of: LH/LHU/SH with `off[0] = 1`, or LW/SW with `off != 0`.
  - A misaligned op still completes the handshake (`req_ready` unchanged).
  - It forces `dmem_en = 0` and `dmem_we = 0`, pushes nothing, and pulses `misalign`.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No check is made; `misalign` is tied to 0.
  - Misaligned ops issue using the truncated shift/mask rules above. Example: SH at `off = 3` writes lane 3 only.

## Test plan
- SB addr `0x1003`, wdata `0x000000A5`: `dmem_we = 1000`, `dmem_din = 0xA5000000`, `dmem_addr = 0x400`.
- SH addr `0x2001`, wdata `0x0000BEEF`, macro undefined: `dmem_we = 0110`, `dmem_din = 0x00BEEF00`.
- Load LBU addr `0x0002`, `dmem_dout = 0x11223344` with `rvalid` one cycle later: `ld_valid` one cycle after that with `ld_data = 0x11223344`, `ld_sft = 2`, `ld_funct3 = LBU`.
- Three loads back-to-back with `DEPTH = 2` and `rvalid` held low: `req_ready` falls after the second load. One `rvalid` restores it. Responses return in issue order with matching `ld_sft`.
- Macro defined, LW addr `0x0006`: `dmem_en = 0`, `misalign = 1` next cycle, `busy` stays 0.
- Issue two loads, assert `rst_n = 0` for one cycle, then pulse `dmem_rvalid` twice: `busy = 0`, no `ld_valid`, and all registered outputs stay 0.
